spi_slave_fsm: RTL and testbench

Transaction controller for the SPI slave peripheral. Consumes the conditioned chip-select and the single-cycle serial-clock rising-edge pulse, counts bits, and drives the control strobes of the 16-bit `shiftregister` (parallel load), the address latch, the data memory write enable and the MISO tri-state buffer. It sits between the input conditioners and the `shiftregister`/address latch/data memory datapath. Each transaction is an address phase (ADDR_BITS address bits then one R/W bit), then a data phase of DATA_BITS bits.

---
 rtl/spi_slave_fsm_pkg.sv | 34 +++
 rtl/spi_bit_counter.sv | 38 +++
 rtl/spi_slave_fsm.sv | 155 +++++++++++++++
 tb/tb_spi_slave_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_fsm_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_fsm_pkg
// Shared definitions for the SPI slave transaction controller:
//   - state_t    : controller state encoding
//   - DEFAULT_*  : default transaction geometry
//   - cnt_width  : bit-counter width for a given address/data geometry
// Ports: none (package).
// -----------------------------------------------------------------------------
package spi_slave_fsm_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        LATCH_ADDR,
        READ_WAIT,
        READ_LOAD,
        READ_SHIFT,
        WRITE_RECV,
        WRITE_COMMIT,
        DONE
    } state_t;

    localparam int DEFAULT_ADDR_BITS    = 7;
    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int DEFAULT_READ_LATENCY = 1;

    // Wide enough to hold the largest phase count (address + R/W, or data).
    function automatic int cnt_width(input int addr_bits, input int data_bits);
        int longest;
        longest = (addr_bits + 1 > data_bits) ? addr_bits + 1 : data_bits;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// -----------------------------------------------------------------------------
// spi_bit_counter
// Bit/cycle counter for the SPI slave controller. Synchronous clear has
// priority over the pulse-gated increment. at_terminal compares the current
// count against a caller-supplied terminal value.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : zero the counter on the next edge
//   inc          : increment on the next edge (ignored while clear is high)
//   terminal     : compare value
//   at_terminal  : count == terminal
// -----------------------------------------------------------------------------
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic         at_terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/spi_slave_fsm.sv
// -----------------------------------------------------------------------------
// spi_slave_fsm
// Transaction controller for the SPI slave. Tracks the address phase
// (ADDR_BITS address bits + one R/W bit) and the DATA_BITS data phase, and
// drives the datapath strobes. All outputs are registered decodes of the
// state being entered, so each is a clean Moore output.
// Optional feature: define SPI_SLAVE_FSM_ABORT_FLAG_EN to get the sticky
// 'aborted' flag; otherwise 'aborted' is tied low and no flag register exists.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   cs_n        : conditioned chip select, active low
//   sclk_rise   : one-cycle pulse per serial-clock rising edge
//   rw          : R/W bit from the shift register (1 = read)
//   sr_load     : shift register parallel load
//   addr_we     : address latch write enable
//   dm_we       : data memory write enable
//   miso_buff   : MISO tri-state enable
//   aborted     : previous transaction ended early (sticky)
// -----------------------------------------------------------------------------
module spi_slave_fsm
    import spi_slave_fsm_pkg::*;
#(
    parameter int ADDR_BITS    = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_rise,
    input  logic rw,
    output logic sr_load,
    output logic addr_we,
    output logic dm_we,
    output logic miso_buff,
    output logic aborted
);

    // The counter also times READ_WAIT, so make sure it can reach READ_LATENCY.
    localparam int BIT_CW  = cnt_width(ADDR_BITS, DATA_BITS);
    localparam int WAIT_CW = $clog2(READ_LATENCY + 1);
    localparam int CW      = (BIT_CW > WAIT_CW) ? BIT_CW : WAIT_CW;

    localparam int WAIT_LAST_I = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LAST_I);

    state_t        state;
    state_t        state_next;
    logic          cnt_clear;
    logic          cnt_inc;
    logic [CW-1:0] cnt_terminal;
    logic          at_terminal;

    spi_bit_counter #(.W(CW)) u_bit_counter (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear),
        .inc         (cnt_inc),
        .terminal    (cnt_terminal),
        .at_terminal (at_terminal)
    );

    // Terminal compares are made against the pre-increment count, so the
    // transition happens on the edge that registers the final pulse.
    always_comb begin
        state_next   = state;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;
        cnt_terminal = DATA_LAST;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (!cs_n) state_next = GET_ADDR;
            end
            GET_ADDR: begin
                cnt_inc      = sclk_rise;
                cnt_terminal = ADDR_LAST;
                if (sclk_rise && at_terminal) state_next = LATCH_ADDR;
            end
            LATCH_ADDR: begin
                cnt_clear = 1'b1;
                if (rw) state_next = (READ_LATENCY == 0) ? READ_LOAD : READ_WAIT;
                else    state_next = WRITE_RECV;
            end
            READ_WAIT: begin
                // Counts clk cycles here, not serial-clock pulses.
                cnt_inc      = 1'b1;
                cnt_terminal = WAIT_LAST;
                if (at_terminal) state_next = READ_LOAD;
            end
            READ_LOAD: begin
                cnt_clear  = 1'b1;
                state_next = READ_SHIFT;
            end
            READ_SHIFT: begin
                cnt_inc = sclk_rise;
                if (sclk_rise && at_terminal) state_next = DONE;
            end
            WRITE_RECV: begin
                cnt_inc = sclk_rise;
                if (sclk_rise && at_terminal) state_next = WRITE_COMMIT;
            end
            WRITE_COMMIT: begin
                state_next = DONE;
            end
            DONE: begin
                if (cs_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Chip select released mid-transaction: abandon it.
        if (cs_n && state != IDLE && state != DONE) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sr_load   <= 1'b0;
            addr_we   <= 1'b0;
            dm_we     <= 1'b0;
            miso_buff <= 1'b0;
        end else begin
            state     <= state_next;
            sr_load   <= (state_next == READ_LOAD);
            addr_we   <= (state_next == LATCH_ADDR);
            dm_we     <= (state_next == WRITE_COMMIT);
            miso_buff <= (state_next == READ_SHIFT);
        end
    end

`ifdef SPI_SLAVE_FSM_ABORT_FLAG_EN
    logic abort;
    logic aborted_q;

    assign abort = cs_n && (state != IDLE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else if (abort) begin
            aborted_q <= 1'b1;
        end else if (state == IDLE && state_next == GET_ADDR) begin
            aborted_q <= 1'b0;
        end
    end

    assign aborted = aborted_q;
`else
    assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_fsm
// Self-checking bench for spi_slave_fsm. Strobe activity is predicted per
// cycle from the transaction being driven and held in exp_q as
// {cycle, sr_load, addr_we, dm_we, miso_buff}; a negedge monitor pops and
// compares, and flags any strobe that was not predicted.
// Honors SPI_SLAVE_FSM_ABORT_FLAG_EN for the expected 'aborted' value.
// -----------------------------------------------------------------------------
module tb_spi_slave_fsm;
    import spi_slave_fsm_pkg::*;

    localparam int ADDR_BITS    = 7;
    localparam int DATA_BITS    = 8;
    localparam int READ_LATENCY = 1;

    localparam logic [3:0] V_SR = 4'b1000;
    localparam logic [3:0] V_AW = 4'b0100;
    localparam logic [3:0] V_DW = 4'b0010;
    localparam logic [3:0] V_MB = 4'b0001;

`ifdef SPI_SLAVE_FSM_ABORT_FLAG_EN
    localparam logic EXP_ABORT = 1'b1;
`else
    localparam logic EXP_ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs_n = 1'b1;
    logic sclk_rise = 1'b0;
    logic rw = 1'b0;
    logic sr_load, addr_we, dm_we, miso_buff, aborted;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [23:0] exp_q[$];

    spi_slave_fsm #(
        .ADDR_BITS    (ADDR_BITS),
        .DATA_BITS    (DATA_BITS),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .rw        (rw),
        .sr_load   (sr_load),
        .addr_we   (addr_we),
        .dm_we     (dm_we),
        .miso_buff (miso_buff),
        .aborted   (aborted)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- drivers ----------------
    // Drive inputs, let one edge sample them, return 1 time unit after it.
    task automatic step(input logic c, input logic r, input logic w);
        cs_n      = c;
        sclk_rise = r;
        rw        = w;
        @(posedge clk);
        #1;
    endtask

    // Predict a strobe vector for the current cycle.
    task automatic push(input logic [3:0] v);
        exp_q.push_back({cyc[19:0], v});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        check({tag, "_strobes"}, 32'({sr_load, addr_we, dm_we, miso_buff}), 32'(0));
    endtask

    task automatic do_write(input int extra_rises);
        step(1'b0, 1'b0, 1'b0);
        check("wr_abort_clear", 32'(aborted), 32'(0));
        for (int i = 0; i <= ADDR_BITS; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == ADDR_BITS) push(V_AW);
            step(1'b0, 1'b0, 1'b0);
        end
        for (int j = 0; j < DATA_BITS; j++) begin
            step(1'b0, 1'b1, 1'b0);
            if (j == DATA_BITS - 1) push(V_DW);
            step(1'b0, 1'b0, 1'b0);
        end
        check("wr_done_state", 32'(dut.state), 32'(DONE));
        for (int k = 0; k < extra_rises; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        check_idle_outputs("wr_end");
    endtask

    // ignored_rise: put one sclk_rise in READ_WAIT. reset_at: data rise index
    // at which reset is asserted (negative = never).
    task automatic do_read(input logic ignored_rise, input int reset_at);
        step(1'b0, 1'b0, 1'b1);
        check("rd_abort_clear", 32'(aborted), 32'(0));
        for (int i = 0; i <= ADDR_BITS; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == ADDR_BITS) push(V_AW);
            step(1'b0, 1'b0, 1'b1);       // READ_WAIT after the last address rise
        end
        step(1'b0, ignored_rise, 1'b1);   // sampled in READ_WAIT; enters READ_LOAD
        push(V_SR);
        step(1'b0, 1'b0, 1'b1);           // enters READ_SHIFT
        push(V_MB);
        for (int j = 0; j < DATA_BITS; j++) begin
            if (j == reset_at) begin
                reset = 1'b1;
                step(1'b0, 1'b0, 1'b1);
                check_idle_outputs("rd_reset");
                check("rd_reset_aborted", 32'(aborted), 32'(0));
                reset = 1'b0;
                step(1'b1, 1'b0, 1'b1);
                check_idle_outputs("rd_after_reset");
                return;
            end
            step(1'b0, 1'b1, 1'b1);
            if (j < DATA_BITS - 1) push(V_MB);
            step(1'b0, 1'b0, 1'b1);
            if (j < DATA_BITS - 1) push(V_MB);
        end
        check("rd_done_state", 32'(dut.state), 32'(DONE));
        step(1'b1, 1'b0, 1'b1);
        check_idle_outputs("rd_end");
    endtask

    task automatic do_abort();
        step(1'b0, 1'b0, 1'b0);
        check("ab_abort_clear", 32'(aborted), 32'(0));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("ab_mid_state", 32'(dut.state), 32'(GET_ADDR));
        step(1'b1, 1'b0, 1'b0);
        check_idle_outputs("ab_now");
        check("ab_flag", 32'(aborted), 32'(EXP_ABORT));
        step(1'b1, 1'b0, 1'b0);
        check_idle_outputs("ab_hold");
        check("ab_flag_sticky", 32'(aborted), 32'(EXP_ABORT));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [3:0] obs;
        logic [3:0] expv;
        logic       have;
        obs  = {sr_load, addr_we, dm_we, miso_buff};
        expv = 4'b0;
        have = 1'b0;
        if (exp_q.size() > 0 && exp_q[0][23:4] == cyc[19:0]) begin
            expv = exp_q[0][3:0];
            void'(exp_q.pop_front());
            have = 1'b1;
        end
        if (!reset && (have || obs != 4'b0))
            check("strobes", {12'(0), cyc[19:0]} << 4 | 32'(obs),
                             {12'(0), cyc[19:0]} << 4 | 32'(expv));
    end

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_idle_outputs("reset");
        check("reset_aborted", 32'(aborted), 32'(0));
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check_idle_outputs("post_reset");

        do_write(0);
        do_read(1'b0, -1);
        do_abort();
        do_write(5);
        do_write(0);
        do_read(1'b1, -1);
        do_read(1'b0, 3);
        do_write(0);

        repeat (3) step(1'b1, 1'b0, 1'b0);
        check("leftover_expected", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
